// File: rtl/stage2_maxpool.sv
// Streaming 2x2 stride-2 max-pool with a half-width row buffer; no frame storage.
// Optional macro MAXPOOL_RELU_EN clamps negative channels to zero before pooling.
module stage2_maxpool #(
    parameter int CH   = 3,
    parameter int DBW  = 20,
    parameter int IN_W = 8,
    parameter int IN_H = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_in_valid,
    input  logic [CH*DBW-1:0]   i_in_fmap,
    output logic                o_ot_valid,
    output logic [CH*DBW-1:0]   o_ot_fmap,
    output logic                o_ot_last
);

    localparam int W  = CH * DBW;
    localparam int HW = IN_W / 2;
    localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 2;
    localparam int BW = CW - 1;
    localparam int RW = (IN_H > 2) ? $clog2(IN_H) : 1;

    generate
        if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_bad_geometry
            $error("stage2_maxpool: IN_W and IN_H must both be even");
        end
    endgenerate

    function automatic logic [W-1:0] actFn(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
`ifdef MAXPOOL_RELU_EN
        for (int k = 0; k < CH; k++) begin
            if (x[k*DBW + DBW - 1]) r[k*DBW +: DBW] = '0;
        end
`endif
        return r;
    endfunction

    // Per-channel signed maximum; on a tie either operand is the same value.
    function automatic logic [W-1:0] chMax(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            if ($signed(a[k*DBW +: DBW]) >= $signed(b[k*DBW +: DBW]))
                r[k*DBW +: DBW] = a[k*DBW +: DBW];
            else
                r[k*DBW +: DBW] = b[k*DBW +: DBW];
        end
        return r;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [W-1:0]  rowbuf_q [HW];
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_fmap_q, out_fmap_d;

    logic [W-1:0]  pix_act;
    logic [W-1:0]  hmax;
    logic [BW-1:0] col_half;
    logic          col_end;
    logic          row_end;
    logic          buf_we;

    assign pix_act  = actFn(i_in_fmap);
    assign hmax     = chMax(hold_q, pix_act);
    assign col_half = col_q[CW-1:1];
    assign col_end  = (col_q == CW'(IN_W - 1));
    assign row_end  = (row_q == RW'(IN_H - 1));

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_fmap_d  = out_fmap_q;
        buf_we      = 1'b0;
        if (i_in_valid) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                hold_d = pix_act;
            end else if (!row_q[0]) begin
                buf_we = 1'b1;
            end else begin
                // Bottom-right pixel of a window completes the vertical compare.
                out_valid_d = 1'b1;
                out_fmap_d  = chMax(rowbuf_q[col_half], hmax);
                out_last_d  = col_end && row_end;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_fmap_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_fmap_q  <= out_fmap_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HW; i++) rowbuf_q[i] <= '0;
        end else if (buf_we) begin
            rowbuf_q[col_half] <= hmax;
        end
    end

    assign o_ot_valid = out_valid_q;
    assign o_ot_last  = out_last_q;
    assign o_ot_fmap  = out_fmap_q;

endmodule

// File: tb/tb_stage2_maxpool.sv
// Self-checking bench for stage2_maxpool: every cycle is compared against a
// frame-array pooling model (window max computed directly from stored pixels).
module tb_stage2_maxpool;

    localparam int CH   = 3;
    localparam int DBW  = 20;
    localparam int IN_W = 8;
    localparam int IN_H = 8;
    localparam int W    = CH * DBW;
    localparam int NPIX = IN_W * IN_H;

    logic         clk;
    logic         reset_n;
    logic         i_in_valid;
    logic [W-1:0] i_in_fmap;
    logic         o_ot_valid;
    logic [W-1:0] o_ot_fmap;
    logic         o_ot_last;

    int checks = 0;
    int errors = 0;
    int pixIdx = 0;
    int pulses = 0;
    logic [W-1:0] frameBuf [IN_H][IN_W];
    logic [W-1:0] expFmap = '0;

    stage2_maxpool #(.CH(CH), .DBW(DBW), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (i_in_valid),
        .i_in_fmap  (i_in_fmap),
        .o_ot_valid (o_ot_valid),
        .o_ot_fmap  (o_ot_fmap),
        .o_ot_last  (o_ot_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mkPix(input int v0, input int v1, input int v2);
        logic [W-1:0] p;
        p = '0;
        p[0*DBW +: DBW] = v0[DBW-1:0];
        p[1*DBW +: DBW] = v1[DBW-1:0];
        p[2*DBW +: DBW] = v2[DBW-1:0];
        return p;
    endfunction

    // Reference: largest of the four window pixels per channel, then the optional clamp.
    function automatic logic [W-1:0] poolRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] r;
        longint vals [4];
        longint best;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            vals[0] = $signed(a[k*DBW +: DBW]);
            vals[1] = $signed(b[k*DBW +: DBW]);
            vals[2] = $signed(c[k*DBW +: DBW]);
            vals[3] = $signed(d[k*DBW +: DBW]);
            best = vals[0];
            for (int i = 1; i < 4; i++) if (vals[i] > best) best = vals[i];
`ifdef MAXPOOL_RELU_EN
            if (best < 0) best = 0;
`endif
            r[k*DBW +: DBW] = best[DBW-1:0];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic expV, input logic expL,
                               input logic [W-1:0] expF);
        checks++;
        assert (o_ot_valid === expV) else begin
            errors++;
            $error("FAIL %s valid: got %b expected %b", tag, o_ot_valid, expV);
        end
        checks++;
        assert (o_ot_last === expL) else begin
            errors++;
            $error("FAIL %s last: got %b expected %b", tag, o_ot_last, expL);
        end
        checks++;
        assert (o_ot_fmap === expF) else begin
            errors++;
            $error("FAIL %s fmap: got %h expected %h", tag, o_ot_fmap, expF);
        end
        if (o_ot_valid === 1'b1) pulses++;
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one beat at the falling edge, then checks the cycle after it and any idle gap cycles.
    task automatic applyStimulus(input logic [W-1:0] pix, input int gap);
        int r, c;
        logic expV, expL;
        r = pixIdx / IN_W;
        c = pixIdx % IN_W;
        frameBuf[r][c] = pix;
        expV = (r % 2 == 1) && (c % 2 == 1);
        expL = expV && (pixIdx == NPIX - 1);
        if (expV) expFmap = poolRef(frameBuf[r-1][c-1], frameBuf[r-1][c], frameBuf[r][c-1], pix);
        i_in_valid = 1'b1;
        i_in_fmap  = pix;
        @(negedge clk);
        checkOutput("beat", expV, expL, expFmap);
        pixIdx = (pixIdx + 1) % NPIX;
        i_in_valid = 1'b0;
        i_in_fmap  = {$urandom, $urandom};
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checkOutput("gap", 1'b0, 1'b0, expFmap);
        end
    endtask

    task automatic sendRampFrame(input int offset, input int maxGap);
        pulses = 0;
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(mkPix(i + offset, i + offset, i + offset),
                          (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0);
            if (i == 9) checkValue("ramp_first", o_ot_fmap, mkPix(9 + offset, 9 + offset, 9 + offset));
        end
        checkCount("ramp_pulse_count", pulses, 16);
        checkValue("ramp_last", o_ot_fmap, mkPix(63 + offset, 63 + offset, 63 + offset));
    endtask

    initial begin
        logic [W-1:0] pix;
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, '0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] gapless ramp frame");
        sendRampFrame(0, 0);

        $display("[TB] channel independence");
        pulses = 0;
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(mkPix(i, 63 - i, 5), 0);
            if (i == 9) checkValue("chan_first", o_ot_fmap, mkPix(9, 63, 5));
        end
        checkCount("chan_pulse_count", pulses, 16);

        $display("[TB] signed values with negative window");
        pulses = 0;
        for (int i = 0; i < NPIX; i++) begin
            pix = mkPix($urandom_range(40, 0) - 20, $urandom_range(40, 0) - 20,
                        $urandom_range(40, 0) - 20);
            if (i == 0)  pix[0 +: DBW] = DBW'(-3);
            if (i == 1)  pix[0 +: DBW] = DBW'(-7);
            if (i == 8)  pix[0 +: DBW] = DBW'(-1);
            if (i == 9)  pix[0 +: DBW] = DBW'(-9);
            applyStimulus(pix, 0);
`ifdef MAXPOOL_RELU_EN
            if (i == 9) checkValue("neg_window_ch0", {{(W-DBW){1'b0}}, o_ot_fmap[0 +: DBW]}, '0);
`else
            if (i == 9) checkValue("neg_window_ch0", {{(W-DBW){1'b0}}, o_ot_fmap[0 +: DBW]},
                                   {{(W-DBW){1'b0}}, {DBW{1'b1}}});
`endif
        end
        checkCount("neg_pulse_count", pulses, 16);

        $display("[TB] gapped ramp frame");
        sendRampFrame(0, 2);

        $display("[TB] random full-range gapped frame");
        pulses = 0;
        for (int i = 0; i < NPIX; i++) applyStimulus({$urandom, $urandom}, $urandom_range(2, 0));
        checkCount("rand_pulse_count", pulses, 16);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 37; i++) applyStimulus({$urandom, $urandom}, 0);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_async", 1'b0, 1'b0, '0);
        i_in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midreset_hold", 1'b0, 1'b0, '0);
        end
        i_in_valid = 1'b0;
        reset_n = 1'b1;
        pixIdx  = 0;
        expFmap = '0;
        @(negedge clk);
        sendRampFrame(0, 1);

        $display("[TB] back-to-back frames");
        sendRampFrame(0, 0);
        sendRampFrame(100, 0);

        repeat (3) begin
            @(negedge clk);
            checkOutput("tail_idle", 1'b0, 1'b0, expFmap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage2_maxpool.md
Name: stage2_maxpool

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the stage-2 convolution core.
- Consumes one CH-channel pixel per valid beat, in raster order, from the conv output map (IN_W x IN_H, default 8x8).
- Emits one CH-channel pooled pixel per completed 2x2 window, producing a (IN_W/2) x (IN_H/2) map for the next stage.
- Uses a half-width row buffer and needs no frame storage.

Parameters:
- CH, 3, channel count; equals the conv output channel count.
- DBW, 20, per-channel data width in bits; signed two's complement.
- IN_W, 8, input map width; must be even.
- IN_H, 8, input map height; must be even.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- i_in_valid  input  1  input pixel strobe; one pixel per asserted cycle.
- i_in_fmap  input  CH*DBW  input pixel; channel k at bits [k*DBW +: DBW].
- o_ot_valid  output  1  pooled pixel strobe; single-cycle pulse.
- o_ot_fmap  output  CH*DBW  pooled pixel, same packing as the input.
- o_ot_last  output  1  asserted together with o_ot_valid for the final pooled pixel of a frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: o_ot_valid=0, o_ot_fmap=0, o_ot_last=0; col/row counters=0; hold register=0; row buffer=0.
- Counters:
  - col advances 0..IN_W-1 and row advances 0..IN_H-1, only on i_in_valid.
  - col wraps to 0 and increments row; at (IN_W-1, IN_H-1), both wrap to 0 and the next beat starts a new frame.
  - No state changes when i_in_valid=0. Arbitrary gaps between beats are allowed and the result is identical to a gapless stream.
- Horizontal stage, per channel, signed compare:
  - Even col: capture the input into hold register h.
  - Odd col: hmax = max(h, input), evaluated combinationally.
- Vertical stage:
  - Even row, odd col: rowbuf[col>>1] <= hmax. rowbuf has IN_W/2 entries of CH*DBW.
  - Odd row, odd col: the output register loads max(rowbuf[col>>1], hmax) per channel, and o_ot_valid pulses on the next cycle.
- Latency: o_ot_valid rises exactly 1 cycle after the accepted beat at odd row / odd col. No output occurs for any other beat.
- Ties: equal values pass unchanged. The comparison is signed, so -1 < 0.
- o_ot_fmap holds its last value between pulses.
- o_ot_last = o_ot_valid for the pooled pixel at (IN_W/2-1, IN_H/2-1).
- Output count: exactly (IN_W/2)*(IN_H/2) pulses per frame; 16 for the defaults.
- No backpressure: downstream must accept every pulse.
- Reset mid-frame: all state clears immediately, any partial window is discarded, and the next valid beat is treated as pixel (0,0).
- Odd IN_W or IN_H: a generate-time check raises an elaboration error. No truncation behaviour is defined.
- Widths: the output width equals the input width (DBW). No arithmetic growth occurs.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: each channel is clamped to 0 when negative (sign bit set) before entering the hold register or comparator. The pooled output is therefore always >= 0, which lets the block absorb the activation of a conv stage that has none.
- Undefined: raw signed values are compared, and negative pooled outputs are possible.
- Latency, valid timing and o_ot_last timing are identical in both builds.

Test Plan:
- Ramp: 8x8 frame, gapless, all channels value = row*8+col -> 16 pulses. First output (0,0) = 9 and last = 63 with o_ot_last=1. Each pulse comes 1 cycle after beats 9, 11, ..., 63.
- Channel independence: ch0=ramp, ch1=63-ramp, ch2=constant 5 -> first output = {9, 63, 5}. ch1 always takes the top-left pixel of each window.
- Signed/negatives: window {-3, -7, -1, -9} on ch0 -> -1 with macro undefined, 0 with MAXPOOL_RELU_EN defined.
- Gapped stream: ramp frame with i_in_valid toggling 1-0-0-1 randomly -> outputs equal the gapless case. Each pulse still comes 1 cycle after its triggering beat, and there are no extra pulses during gaps.
- Reset mid-frame: assert reset_n=0 after 37 beats, release, then send a full ramp frame -> outputs are all 0 during reset, and the following frame is exactly 16 correct pulses with no residue from the aborted frame.
- Back-to-back frames: two consecutive ramp frames (second offset +100) -> 32 pulses, o_ot_last on pulses 16 and 32, and the second frame's first output = 109.
